// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch sequencer: word width,
// state encoding and the state enum built on that encoding.
package fetch_unit_pkg;

    // Instruction/address word width, common with the PC and instruction memory
    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    // State encoding
    localparam logic [1:0] REQ  = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    typedef enum logic [1:0] {
        S_REQ  = REQ,
        S_HOLD = HOLD,
        S_HALT = HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read bus: request/address out, acknowledge/data back.
// The fetch unit is the master; the instruction memory is the slave.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  mem_req;
    word_t mem_addr;
    logic  mem_ack;
    word_t mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for the memory acknowledge: clear has priority over
// increment, and hit flags that the count equals LIMIT.
module fetch_timeout_ctr #(
    parameter logic [7:0] LIMIT = 8'd14
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    logic [7:0] count_r;

    // Count unacknowledged request cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (inc) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign hit = (count_r == LIMIT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: requests the word at the current PC, latches
// it into a one-entry instruction register, hands it to decode, and drives
// the PC increment/load controls including jump redirects. A wait counter
// halts fetching with a sticky error if memory never acknowledges.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  word_t               pc_in,
    output logic                pc_inc,
    output logic                pc_write,
    output word_t               pc_load_val,
    fetch_unit_if.master        mem,
    output logic                ir_valid,
    input  logic                ir_ready,
    output word_t               ir_out,
    input  logic                jmp_valid,
    input  word_t               jmp_addr,
    input  logic                hlt,
    output logic                halted,
    output logic                fetch_err
);

    // The counter holds the number of unacked cycles already spent, so the
    // current cycle is the ACK_TIMEOUT-th one when it equals ACK_TIMEOUT-1.
    localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    word_t        ir_out_r;
    logic         ir_valid_r;
    logic         halted_r;
    logic         fetch_err_r;
    logic         hlt_pend_r;

    logic         req_s;
    logic         inc_s;
    logic         write_s;
    word_t        load_val_s;
    logic         capture_s;
    logic         timeout_s;
    logic         xfer_s;
    logic         ctr_clr_s;
    logic         ctr_inc_s;
    logic         ctr_hit_s;

    fetch_timeout_ctr #(
        .LIMIT (LAST_WAIT)
    ) u_timeout_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr_s),
        .inc (ctr_inc_s),
        .hit (ctr_hit_s)
    );

    // The instruction register only holds a word while in HOLD
    assign xfer_s = ir_valid_r && ir_ready;

    // Next-state and combinational bus/PC controls; jumps take priority over everything
    always_comb begin
        state_nxt_s = state_r;
        req_s       = 1'b0;
        inc_s       = 1'b0;
        write_s     = 1'b0;
        load_val_s  = 16'h0000;
        capture_s   = 1'b0;
        timeout_s   = 1'b0;
        ctr_clr_s   = 1'b1;
        ctr_inc_s   = 1'b0;
        case (state_r)
            S_REQ: begin
                req_s = 1'b1;
                if (jmp_valid) begin
                    // Any same-cycle ack is dropped; a fresh request starts at the target
                    write_s     = 1'b1;
                    load_val_s  = jmp_addr;
                    state_nxt_s = S_REQ;
                end else if (mem.mem_ack) begin
                    capture_s   = 1'b1;
                    inc_s       = 1'b1;
                    state_nxt_s = S_HOLD;
                end else if (ctr_hit_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = S_HALT;
                end else begin
                    ctr_clr_s   = 1'b0;
                    ctr_inc_s   = 1'b1;
                    state_nxt_s = S_REQ;
                end
            end
            S_HOLD: begin
                if (jmp_valid) begin
                    write_s     = 1'b1;
                    load_val_s  = jmp_addr;
                    state_nxt_s = S_REQ;
                end else if (xfer_s) begin
                    if (hlt || hlt_pend_r) begin
                        state_nxt_s = S_HALT;
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_HALT: begin
                state_nxt_s = S_HALT;
            end
            default: begin
                state_nxt_s = S_HALT;
            end
        endcase
        // Keep the bus and PC quiet while reset is held
        if (!rst) begin
            req_s      = 1'b0;
            inc_s      = 1'b0;
            write_s    = 1'b0;
            load_val_s = 16'h0000;
        end else begin
            load_val_s = load_val_s;
        end
    end

    // State, instruction register and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= S_REQ;
            ir_out_r    <= 16'h0000;
            ir_valid_r  <= 1'b0;
            halted_r    <= 1'b0;
            fetch_err_r <= 1'b0;
            hlt_pend_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ir_valid_r  <= (state_nxt_s == S_HOLD);
            halted_r    <= (state_nxt_s == S_HALT);
            fetch_err_r <= fetch_err_r | timeout_s;
            hlt_pend_r  <= hlt_pend_r | (hlt && (state_r != S_HALT));
            if (capture_s) begin
                ir_out_r <= mem.mem_rdata;
            end else begin
                ir_out_r <= ir_out_r;
            end
        end
    end

    assign mem.mem_req  = req_s;
    assign mem.mem_addr = req_s ? pc_in : 16'h0000;
    assign pc_inc       = inc_s;
    assign pc_write     = write_s;
    assign pc_load_val  = load_val_s;
    assign ir_valid     = ir_valid_r;
    assign ir_out       = ir_out_r;
    assign halted       = halted_r;
    assign fetch_err    = fetch_err_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a program counter and a latency-programmable
// instruction memory around the DUT, a transaction-level reference model
// compared against the outputs every cycle, and directed scenarios with
// hand-computed literal expectations.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int TO = 4;

    logic  clk = 1'b0;
    logic  rst;
    word_t pc_in;
    logic  pc_inc;
    logic  pc_write;
    word_t pc_load_val;
    logic  ir_valid;
    logic  ir_ready;
    word_t ir_out;
    logic  jmp_valid;
    word_t jmp_addr;
    logic  hlt;
    logic  halted;
    logic  fetch_err;

    fetch_unit_if bus ();

    fetch_unit #(.ACK_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_inc      (pc_inc),
        .pc_write    (pc_write),
        .pc_load_val (pc_load_val),
        .mem         (bus),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .ir_out      (ir_out),
        .jmp_valid   (jmp_valid),
        .jmp_addr    (jmp_addr),
        .hlt         (hlt),
        .halted      (halted),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic word_t mem_data(input word_t a);
        return a ^ 16'hBEEF;
    endfunction

    // Program counter
    word_t pc = 16'h0000;
    always @(posedge clk) begin
        if (pc_write)    pc <= pc_load_val;
        else if (pc_inc) pc <= pc + 16'h0001;
    end
    assign pc_in = pc;

    // Instruction memory: ack after ack_lat waiting cycles unless ack_off
    int ack_lat = 0;
    bit ack_off = 1'b0;
    int wcnt    = 0;
    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ack && !pc_write) wcnt <= wcnt + 1;
        else                                          wcnt <= 0;
    end
    always @(negedge clk) begin
        #1;
        bus.mem_ack = bus.mem_req && !ack_off && (wcnt >= ack_lat);
    end
    assign bus.mem_rdata = mem_data(bus.mem_addr);

    // Reference model: fetching / holding a word / halted
    bit    started = 1'b0;
    bit    m_halted, m_err, m_hold, m_hlt;
    word_t m_word;
    int    m_wait;
    word_t delivered[$];
    bit    exp_req, exp_inc, exp_write;

    always @(negedge clk) begin
        #3;
        if (started) begin
            exp_req   = rst && !m_halted && !m_hold;
            exp_write = rst && !m_halted && jmp_valid;
            exp_inc   = exp_req && bus.mem_ack && !jmp_valid;
            chk("mem_req", bus.mem_req, exp_req);
            if (exp_req) chk("mem_addr", bus.mem_addr, pc);
            chk("pc_inc", pc_inc, exp_inc);
            chk("pc_write", pc_write, exp_write);
            chk("pc_load_val", pc_load_val, exp_write ? jmp_addr : 16'h0000);
            chk("inc_write_excl", pc_inc & pc_write, 1'b0);
            chk("ir_valid", ir_valid, m_hold);
            chk("ir_out", ir_out, m_word);
            chk("halted", halted, m_halted);
            chk("fetch_err", fetch_err, m_err);
        end
        // Advance the model across the coming edge
        if (!rst) begin
            m_halted = 1'b0; m_err = 1'b0; m_hold = 1'b0; m_hlt = 1'b0;
            m_word = 16'h0000; m_wait = 0; started = 1'b1;
        end else if (!m_halted) begin
            if (hlt) m_hlt = 1'b1;
            if (jmp_valid) begin
                if (m_hold && ir_ready) delivered.push_back(m_word);
                m_hold = 1'b0;
                m_wait = 0;
            end else if (m_hold) begin
                if (ir_ready) begin
                    delivered.push_back(m_word);
                    m_hold = 1'b0;
                    m_wait = 0;
                    if (m_hlt) m_halted = 1'b1;
                end
            end else if (bus.mem_ack) begin
                m_word = mem_data(pc);
                m_hold = 1'b1;
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_err = 1'b1;
                    m_halted = 1'b1;
                end
            end
        end
    end

    task automatic wait_req();
        for (int i = 0; i < 8 && !bus.mem_req; i++) @(negedge clk);
        chk("wait_req", bus.mem_req, 1'b1);
    endtask

    int    nreq, ninc, n0;
    bit    stable;
    word_t a0, held;

    initial begin
        rst = 1'b0; ir_ready = 1'b1; jmp_valid = 1'b0; jmp_addr = 16'h0000; hlt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #3;
        chk("t0_req_after_reset", bus.mem_req, 1'b1);
        chk("t0_addr", bus.mem_addr, 16'h0000);

        // Zero-wait stream: words from 0x0000, 0x0001, 0x0002
        for (int i = 0; i < 20 && delivered.size() < 3; i++) @(negedge clk);
        chk("t1_count", delivered.size(), 3);
        chk("t1_w0", delivered[0], 16'hBEEF);
        chk("t1_w1", delivered[1], 16'hBEEE);
        chk("t1_w2", delivered[2], 16'hBEED);
        chk("t1_pc", pc, 16'h0003);

        // Ack on the fourth request cycle
        wait_req();
        ack_lat = 3;
        a0 = pc; nreq = 0; ninc = 0; stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (!bus.mem_req) break;
            nreq++;
            if (bus.mem_addr != a0) stable = 1'b0;
            if (pc_inc) ninc++;
            @(negedge clk);
        end
        ack_lat = 0;
        chk("t2_req_cycles", nreq, 4);
        chk("t2_inc_count", ninc, 1);
        chk("t2_addr_stable", stable, 1'b1);
        chk("t2_no_err", fetch_err, 1'b0);

        // Decode stalls for 5 cycles
        @(negedge clk);
        ir_ready = 1'b0;
        for (int i = 0; i < 6 && !ir_valid; i++) @(negedge clk);
        held = ir_out;
        chk("t3_word", held, 16'hBEEB);
        repeat (5) begin
            #3;
            chk("t3_valid", ir_valid, 1'b1);
            chk("t3_stable", ir_out, held);
            chk("t3_no_req", bus.mem_req, 1'b0);
            chk("t3_no_inc", pc_inc, 1'b0);
            @(negedge clk);
        end
        ir_ready = 1'b1;

        // Jump coinciding with an ack
        wait_req();
        n0 = delivered.size();
        jmp_valid = 1'b1; jmp_addr = 16'h0040;
        #3;
        chk("t4_pc_write", pc_write, 1'b1);
        chk("t4_load_val", pc_load_val, 16'h0040);
        chk("t4_no_inc", pc_inc, 1'b0);
        @(negedge clk);
        jmp_valid = 1'b0;
        #3;
        chk("t4_req", bus.mem_req, 1'b1);
        chk("t4_target", bus.mem_addr, 16'h0040);
        @(negedge clk);
        #4;
        chk("t4_one_word", delivered.size(), n0 + 1);
        chk("t4_word", delivered[$], 16'hBEAF);

        // Halt requested while a request is in flight
        @(negedge clk);
        wait_req();
        n0 = delivered.size();
        ack_lat = 2; hlt = 1'b1;
        @(negedge clk);
        hlt = 1'b0;
        for (int i = 0; i < 12 && !halted; i++) @(negedge clk);
        ack_lat = 0;
        chk("t5_halted", halted, 1'b1);
        chk("t5_one_word", delivered.size(), n0 + 1);
        chk("t5_word", delivered[$], 16'hBEAE);
        repeat (3) begin
            #3;
            chk("t5_no_req", bus.mem_req, 1'b0);
            @(negedge clk);
        end

        // Reset out of HALT, then a memory that never acknowledges
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("t6_reset_halted", halted, 1'b0);
        @(negedge clk);
        rst = 1'b1; ack_off = 1'b1;
        for (int i = 1; i <= TO; i++) begin
            #3;
            chk("t6_waiting_req", bus.mem_req, 1'b1);
            chk("t6_not_halted", halted, 1'b0);
            @(negedge clk);
        end
        #3;
        chk("t6_halted", halted, 1'b1);
        chk("t6_err", fetch_err, 1'b1);
        chk("t6_no_req", bus.mem_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("t6_err_cleared", fetch_err, 1'b0);
        chk("t6_halt_cleared", halted, 1'b0);
        @(negedge clk);
        rst = 1'b1; ack_off = 1'b0;
        #3;
        chk("t6_req_resumes", bus.mem_req, 1'b1);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer that sits directly downstream of the program counter and upstream of the decode/control stage. It reads the current PC, runs a request/acknowledge read against instruction memory, and latches the returned word into a one-entry instruction register. It drives the PC's increment and load controls, including redirects for jumps. A wait-cycle counter guards against a memory that never acknowledges.

## Interface
- ACK_TIMEOUT, 15: maximum cycles `mem_req` may stay high without `mem_ack` before a fetch error is raised (1..255).
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on `clk`).
- pc_in  input  16  current PC value from the program counter.
- pc_inc  output  1  PC increment strobe; one cycle per accepted fetch.
- pc_write  output  1  PC load strobe for redirects.
- pc_load_val  output  16  value placed on the PC load bus when `pc_write` is 1; 0 otherwise.
- mem_req  output  1  instruction read request.
- mem_addr  output  16  read address; equals `pc_in` whenever `mem_req` is 1.
- mem_ack  input  1  memory acknowledge; `mem_rdata` is valid in the same cycle.
- mem_rdata  input  16  instruction word.
- ir_valid  output  1  the instruction register holds an undelivered word.
- ir_ready  input  1  decode accepts the word.
- ir_out  output  16  instruction register contents.
- jmp_valid  input  1  redirect request from execute.
- jmp_addr  input  16  redirect target.
- hlt  input  1  stop fetching.
- halted  output  1  fetch has stopped.
- fetch_err  output  1  sticky flag: `mem_ack` timed out.

## Operation
- States: REQ, HOLD, HALT.
- REQ:
  - `mem_req` = 1 and `mem_addr` = `pc_in`.
  - On `mem_ack`: capture `mem_rdata` into `ir_out`, assert `pc_inc` that same cycle, then go to HOLD.
- HOLD:
  - `ir_valid` = 1 and `mem_req` = 0.
  - On `ir_valid && ir_ready`, the word transfers and the state returns to REQ.
- Wait counter (8-bit):
  - Clears on entry to REQ and on every `mem_ack`.
  - Increments each REQ cycle that has no ack.
  - When it reaches ACK_TIMEOUT with no ack: set `fetch_err`, go to HALT.
- HALT:
  - `halted` = 1; no requests and no PC strobes.
  - Exit only through reset.
- `hlt` in HOLD:
  - The pending word is still delivered.
  - After it transfers, go to HALT instead of REQ.
- `hlt` in REQ:
  - Takes effect only after the in-flight request completes.
  - Once acked, go to HOLD as normal; the hlt is latched and applied on that transfer.
- `jmp_valid` (any state except HALT; highest priority):
  - `pc_write` = 1 and `pc_load_val` = `jmp_addr` in the same cycle.
  - `pc_inc` is forced to 0.
  - An ack arriving in the same cycle is discarded: the word is not captured and the transaction counts as complete.
  - `ir_valid` clears next cycle and the state becomes REQ.
  - A transfer (`ir_valid && ir_ready`) in the same cycle still counts as delivered.
- `pc_inc` and `pc_write` are never 1 together.
- Reset values:
  - State REQ; `ir_out` = 0x0000.
  - Latched hlt cleared and counter 0.
  - `ir_valid`, `halted`, `fetch_err`, `pc_inc` and `pc_write` all 0.
  - `mem_req` rises in the first cycle after reset is released.
- Reset asserted mid-transaction abandons the request; the memory must tolerate `mem_req` dropping without an ack.

## Timing
- `mem_req`, `mem_addr`, `pc_inc`, `pc_write` and `pc_load_val` are combinational from state and inputs; all state updates on the `clk` edge.
- Zero-wait memory (ack in the first REQ cycle): 1 cycle in REQ, then `ir_valid` in the next cycle.
- Back-to-back throughput with `ir_ready` held at 1: one instruction per 2 cycles (REQ, HOLD, REQ, ...).
- `pc_in` has already advanced when the next REQ begins, because the PC updates on the edge that ends the acked REQ cycle.
- Redirect: `pc_write` in cycle N, and the first request to `jmp_addr` is presented in cycle N+1.
- Timeout: `fetch_err` and `halted` become 1 on the edge after ACK_TIMEOUT unacked REQ cycles.

## Structure
- The shared package holds:
  - the state encoding localparams (REQ=2'd0, HOLD=2'd1, HALT=2'd2);
  - the 16-bit word-width constant, shared with the program counter and memory.
- The wait counter is a natural sub-module, `fetch_timeout_ctr`: a load-clear/increment counter with a compare-equal output.
- Everything else stays flat in `fetch_unit`.

## Test plan
- Reset release, zero-wait memory, `ir_ready`=1, PC starting at 0x0000 -> `mem_addr` sequence 0x0000, 0x0001, 0x0002; one `pc_inc` per acked cycle; `ir_out` matches memory contents.
- Ack delayed 3 cycles -> `mem_req` held 4 cycles with a stable address; exactly one `pc_inc`; `fetch_err` stays 0.
- `ir_ready`=0 for 5 cycles in HOLD -> `ir_valid` and `ir_out` stay stable, no `mem_req`, no `pc_inc`.
- `jmp_valid` with `jmp_addr`=0x0040 in the same cycle as `mem_ack` -> `pc_write`=1, `pc_load_val`=0x0040, `pc_inc`=0, word discarded; next request is to 0x0040.
- ACK_TIMEOUT=4 with no ack -> `fetch_err` and `halted` go to 1 after 4 REQ cycles; no further `mem_req`; reset clears both.
- `hlt` asserted in REQ -> the pending fetch completes and the word is delivered, then `halted`=1 and `mem_req` stays 0.
